qspi_arb_ctrl: RTL
==================

# qspi_arb_ctrl

Read-only QSPI sequencer and two-port arbiter for the shared QSPI PMOD: one flash and two PSRAM chips (RAM A, RAM B) on common clock and 4-bit data pins. It arbitrates between the CPU fetch/load port (port 0) and the 2A03 APU/DMA sample port (port 1), runs one quad-read transaction at a time and compensates for board and pad latency through a configurable capture delay. It sits between the tinyQV memory interface and the top-level `uio` pin mux.

## Interface
- `ADDR_W`, 24: address width, in bytes.
- `MAX_LAT`, 4: largest supported capture latency; larger `latency` values are clamped to this.

- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `latency` in 3: extra capture delay in clk cycles, 0..4. Latched at grant.
- `p0_req`, `p1_req` in 1: request. Hold high with stable fields until the matching ack.
- `p0_addr`, `p1_addr` in ADDR_W: byte address.
- `p0_sel`, `p1_sel` in 2: target. 0 = flash, 1 = RAM A, 2 = RAM B, 3 = none.
- `p0_len`, `p1_len` in 2: byte count minus 1 (0..3 means 1..4 bytes).
- `p0_ack`, `p1_ack` out 1: one-cycle completion pulse.
- `rdata` out 32: read data, valid in the ack cycle. Little-endian; unread bytes are 0.
- `qspi_clk` out 1: SCK.
- `qspi_flash_cs_n`, `qspi_ram_a_cs_n`, `qspi_ram_b_cs_n` out 1: active-low chip selects.
- `qspi_data_out` out 4, `qspi_data_oe` out 4, `qspi_data_in` in 4: quad data pins.

## Operation
- States: IDLE, CMD, ADDR, DUMMY, DATA, WAIT, DONE.
- **IDLE arbitration**
  - Port 0 has fixed priority.
  - Starvation guard: if port 1 has lost 2 consecutive grants while requesting, it wins the next grant.
  - The loss counter clears whenever port 1 is granted.
  - Granting latches addr, sel, len, the clamped latency and the owner.
- **SCK**
  - SCK toggles every clk in CMD, ADDR, DUMMY and DATA: low phase first, then high phase. One SCK period is 2 clk.
  - Outputs change only at the start of a low phase.
- **CMD**: 8 SCK. Sends 0xEB MSB-first on `data_out[0]` with `oe` = 4'b0001.
- **ADDR**: 6 SCK. Sends the address on all 4 lines, high nibble first, with `oe` = 4'hF.
- **DUMMY**: 6 SCK with `oe` = 0.
- **DATA**
  - 2×(len+1) SCK with `oe` = 0.
  - Nibble *i* is captured on the clk edge that is `lat` cycles after the edge ending its SCK-high phase. A delayed capture-strobe shift register provides this.
  - Within each byte the high nibble is received first. Byte *k* goes to `rdata[8k+7:8k]`.
- **WAIT**: `lat`+1 clk. SCK is held low and CS stays asserted, so late nibbles are captured.
- **DONE**: 1 clk. Owner ack = 1, `rdata` is valid, all CS high. The next state is IDLE.
- **sel = 3**: grant, then go directly to DONE. No CS is asserted and `rdata` = 0.
- **Reset values**: all CS = 1, `qspi_clk` = 0, `data_out` = 0, `oe` = 0, acks = 0, `rdata` = 0, state IDLE, loss counter 0.
- **Reset mid-transaction**: all of the reset values above apply at the next clk edge. No ack is issued.

## Timing
- Request sampled high in IDLE at cycle 0 → CS low and CMD starting at cycle 1.
- CMD ends at cycle 16, ADDR at cycle 28 and DUMMY at cycle 40.
- DATA runs for cycles 41..40+4(len+1).
- Ack cycle = 42 + 4(len+1) + lat. Example: 4 bytes with lat 0 gives ack at cycle 58.
- sel = 3: ack at cycle 1.
- CS is high for at least 2 clk between transactions (DONE plus IDLE). The next grant is at earliest the cycle after DONE.
- Requests arriving during a transaction wait. Arbitration uses only the IDLE-cycle sample.
- Both requests in the same IDLE cycle: the winner is set by the priority and starvation rule. The loser keeps `req` high and is not acked.

## Test plan
- **Single flash read**: flash holds 0x11 0x22 0x33 0x44 at 0x000100. Port 0 requests addr 0x000100, sel 0, len 3, lat 0 → ack at cycle 58 with `rdata` = 0x44332211; only the flash CS is low; the data pins carry 0xEB, then 0x000100.
- **Latency sweep**: same read at lat 0, 1, 2, 3, 4 and 7, with the bench's data delay set equal to lat → `rdata` = 0x44332211 every time. Ack cycle = 58 + lat, with lat 7 clamped to 4 (ack at cycle 62).
- **RAM B 1-byte read**: port 1 reads addr 0x000005, sel 2, len 0; RAM B byte = 0xA5 → `rdata` = 0x000000A5, ack at cycle 46, only `ram_b_cs_n` low.
- **Starvation guard**: both ports request continuously → grant order is 0, 0, 1, 0, 0, 1. Each ack pulses for exactly 1 cycle and consecutive transactions are separated by CS high for 2 or more clk.
- **sel = 3**: ack at cycle 1 with `rdata` = 0; every CS stays high and `qspi_clk` stays 0.
- **Reset mid-DATA**: assert `rst` at cycle 45 → at the next edge all CS = 1, `oe` = 0, no ack. After reset is released, a new port 0 read completes correctly.

Source files
------------

// File: rtl/qspi_arb_ctrl_if.sv
// Client-side bundle of qspi_arb_ctrl: two request ports, shared read data and capture latency.
// master drives requests, slave (the controller) returns acks and data.
interface qspi_arb_ctrl_if #(
  parameter int unsigned ADDR_W = 24
);
  logic [2:0]        latency;
  logic              p0_req;
  logic [ADDR_W-1:0] p0_addr;
  logic [1:0]        p0_sel;
  logic [1:0]        p0_len;
  logic              p0_ack;
  logic              p1_req;
  logic [ADDR_W-1:0] p1_addr;
  logic [1:0]        p1_sel;
  logic [1:0]        p1_len;
  logic              p1_ack;
  logic [31:0]       rdata;

  modport master (
    output latency, p0_req, p0_addr, p0_sel, p0_len, p1_req, p1_addr, p1_sel, p1_len,
    input  p0_ack, p1_ack, rdata
  );

  modport slave (
    input  latency, p0_req, p0_addr, p0_sel, p0_len, p1_req, p1_addr, p1_sel, p1_len,
    output p0_ack, p1_ack, rdata
  );
endinterface

// File: rtl/qspi_arb_ctrl.sv
// Two-port arbiter and quad-read (0xEB) sequencer for a shared flash / dual-PSRAM QSPI PMOD.
// All pin outputs are registered and derived from the next state so they line up with SCK phases.
module qspi_arb_ctrl #(
  parameter int unsigned ADDR_W  = 24,
  parameter int unsigned MAX_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  qspi_arb_ctrl_if.slave   bus,
  output logic             qspi_clk,
  output logic             qspi_flash_cs_n,
  output logic             qspi_ram_a_cs_n,
  output logic             qspi_ram_b_cs_n,
  output logic [3:0]       qspi_data_out,
  output logic [3:0]       qspi_data_oe,
  input  logic [3:0]       qspi_data_in
);

  localparam logic [7:0] QuadRdCmd = 8'hEB;
  localparam logic [2:0] MaxLat    = 3'(MAX_LAT);

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StDummy, StData, StWait, StDone} state_e;

  state_e              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [1:0]          loss_q;
  logic                owner_q;
  logic [1:0]          sel_q;
  logic [1:0]          len_q;
  logic [2:0]          lat_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [MAX_LAT-1:0]  stb_q;
  logic [2:0]          nib_q;
  logic [31:0]         rx_q;

  logic                grant, gnt1, own_n, strobe_now, cap, cs_on_d, sck_on_d;
  logic [1:0]          sel_g, sel_n;
  logic [MAX_LAT:0]    taps;
  logic [23:0]         addr_tx;
  logic [3:0]          dout_d, oe_d;

  // Port 1 wins outright once it has lost two grants in a row while requesting.
  assign gnt1    = bus.p1_req && (!bus.p0_req || loss_q == 2'd2);
  assign sel_g   = gnt1 ? bus.p1_sel : bus.p0_sel;
  assign grant   = (state_q == StIdle) && (bus.p0_req || bus.p1_req);
  assign sel_n   = grant ? sel_g : sel_q;
  assign own_n   = grant ? gnt1 : owner_q;
  assign addr_tx = 24'(addr_q);

  // Strobe marks the cycle ending each SCK-high phase; the tap picks it up lat cycles later.
  assign strobe_now = (state_q == StData) && cnt_q[0];
  assign taps       = {stb_q, strobe_now};
  assign cap        = taps[lat_q];

  assign cs_on_d  = state_d inside {StCmd, StAddr, StDummy, StData, StWait};
  assign sck_on_d = state_d inside {StCmd, StAddr, StDummy, StData};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 5'd1;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (grant) state_d = (sel_g == 2'd3) ? StDone : StCmd;
      end
      StCmd:   if (cnt_q == 5'd15) begin state_d = StAddr;  cnt_d = '0; end
      StAddr:  if (cnt_q == 5'd11) begin state_d = StDummy; cnt_d = '0; end
      StDummy: if (cnt_q == 5'd11) begin state_d = StData;  cnt_d = '0; end
      StData:  if (cnt_q == {1'b0, len_q, 2'b11}) begin state_d = StWait; cnt_d = '0; end
      StWait:  if (cnt_q == {2'b00, lat_q}) begin state_d = StDone; cnt_d = '0; end
      default: begin state_d = StIdle; cnt_d = '0; end
    endcase
  end

  always_comb begin
    dout_d = '0;
    oe_d   = '0;
    case (state_d)
      StCmd: begin
        dout_d = {3'b000, QuadRdCmd[~cnt_d[3:1]]};
        oe_d   = 4'b0001;
      end
      StAddr: begin
        dout_d = addr_tx[{3'd5 - cnt_d[3:1], 2'b00} +: 4];
        oe_d   = 4'hF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      loss_q          <= '0;
      owner_q         <= 1'b0;
      sel_q           <= 2'd3;
      len_q           <= '0;
      lat_q           <= '0;
      addr_q          <= '0;
      stb_q           <= '0;
      nib_q           <= '0;
      rx_q            <= '0;
      qspi_clk        <= 1'b0;
      qspi_flash_cs_n <= 1'b1;
      qspi_ram_a_cs_n <= 1'b1;
      qspi_ram_b_cs_n <= 1'b1;
      qspi_data_out   <= '0;
      qspi_data_oe    <= '0;
      bus.p0_ack      <= 1'b0;
      bus.p1_ack      <= 1'b0;
      bus.rdata       <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stb_q   <= MAX_LAT'({stb_q, strobe_now});
      if (grant) begin
        owner_q <= gnt1;
        sel_q   <= sel_g;
        addr_q  <= gnt1 ? bus.p1_addr : bus.p0_addr;
        len_q   <= gnt1 ? bus.p1_len : bus.p0_len;
        lat_q   <= (bus.latency > MaxLat) ? MaxLat : bus.latency;
        loss_q  <= gnt1 ? 2'd0 : (bus.p1_req ? loss_q + 2'd1 : loss_q);
        stb_q   <= '0;
        nib_q   <= '0;
        rx_q    <= '0;
      end else if (cap) begin
        // High nibble of each byte arrives first; byte k lands in rx_q[8k +: 8].
        rx_q[{nib_q[2:1], ~nib_q[0], 2'b00} +: 4] <= qspi_data_in;
        nib_q <= nib_q + 3'd1;
      end
      qspi_clk        <= sck_on_d & cnt_d[0];
      qspi_flash_cs_n <= !(cs_on_d && sel_n == 2'd0);
      qspi_ram_a_cs_n <= !(cs_on_d && sel_n == 2'd1);
      qspi_ram_b_cs_n <= !(cs_on_d && sel_n == 2'd2);
      qspi_data_out   <= dout_d;
      qspi_data_oe    <= oe_d;
      bus.p0_ack      <= (state_d == StDone) && !own_n;
      bus.p1_ack      <= (state_d == StDone) && own_n;
      if (state_d == StDone) bus.rdata <= (sel_n == 2'd3) ? 32'd0 : rx_q;
    end
  end

endmodule
